// File: rtl/rename_rat_if.sv
// Bundle of every rename-stage signal except clk/rst: decode, free list, ROB free port,
// renamed output, commit and flush. slave is the rename stage, master its environment.
interface rename_rat_if #(
  parameter int ARCH_REG_WIDTH = 5,
  parameter int PHY_REG_WIDTH  = 6
);
  logic                      dec_valid_i;
  logic                      dec_ready_o;
  logic [ARCH_REG_WIDTH-1:0] dec_rs1_i;
  logic [ARCH_REG_WIDTH-1:0] dec_rs2_i;
  logic [ARCH_REG_WIDTH-1:0] dec_rd_i;
  logic                      dec_rd_wen_i;

  logic                      fl_empty_i;
  logic [PHY_REG_WIDTH-1:0]  fl_rdata_i;
  logic                      fl_rd_en_o;
  logic                      fl_wr_en_o;
  logic [PHY_REG_WIDTH-1:0]  fl_wdata_o;

  logic                      rob_free_valid_i;
  logic [PHY_REG_WIDTH-1:0]  rob_free_prd_i;

  logic                      ren_valid_o;
  logic                      ren_ready_i;
  logic [PHY_REG_WIDTH-1:0]  ren_prs1_o;
  logic [PHY_REG_WIDTH-1:0]  ren_prs2_o;
  logic [PHY_REG_WIDTH-1:0]  ren_prd_o;
  logic [PHY_REG_WIDTH-1:0]  ren_old_prd_o;
  logic                      ren_rd_wen_o;

  logic                      cmt_valid_i;
  logic                      cmt_rd_wen_i;
  logic [ARCH_REG_WIDTH-1:0] cmt_rd_i;
  logic [PHY_REG_WIDTH-1:0]  cmt_prd_i;

  logic                      flush_i;

  // Debug view of the rename FSM: 0 = INIT (seeding free list), 1 = RUN.
  logic [0:0]                dbg_state;

  modport slave (
    input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rd_i, dec_rd_wen_i,
    output dec_ready_o,
    input  fl_empty_i, fl_rdata_i,
    output fl_rd_en_o, fl_wr_en_o, fl_wdata_o,
    input  rob_free_valid_i, rob_free_prd_i,
    output ren_valid_o, ren_prs1_o, ren_prs2_o, ren_prd_o, ren_old_prd_o, ren_rd_wen_o,
    input  ren_ready_i,
    input  cmt_valid_i, cmt_rd_wen_i, cmt_rd_i, cmt_prd_i,
    input  flush_i,
    output dbg_state
  );

  modport master (
    output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rd_i, dec_rd_wen_i,
    input  dec_ready_o,
    output fl_empty_i, fl_rdata_i,
    input  fl_rd_en_o, fl_wr_en_o, fl_wdata_o,
    output rob_free_valid_i, rob_free_prd_i,
    input  ren_valid_o, ren_prs1_o, ren_prs2_o, ren_prd_o, ren_old_prd_o, ren_rd_wen_o,
    output ren_ready_i,
    output cmt_valid_i, cmt_rd_wen_i, cmt_rd_i, cmt_prd_i,
    output flush_i,
    input  dbg_state
  );
endinterface

// File: rtl/rename_rat.sv
// Single-issue register rename: speculative + architectural RAT, free-list seeding after
// reset, one rename per cycle into a registered output stage, flush restores from arch RAT.
module rename_rat #(
  parameter int ARCH_REG_NUM   = 32,
  parameter int ARCH_REG_WIDTH = 5,
  parameter int PHY_REG_NUM    = 64,
  parameter int PHY_REG_WIDTH  = 6
) (
  input logic         clk,
  input logic         rst,
  rename_rat_if.slave bus
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [PHY_REG_WIDTH-1:0]  INIT_FIRST = PHY_REG_WIDTH'(ARCH_REG_NUM);
  localparam logic [PHY_REG_WIDTH-1:0]  INIT_LAST  = PHY_REG_WIDTH'(PHY_REG_NUM - 1);
  localparam logic [PHY_REG_WIDTH-1:0]  PRD_ZERO   = '0;
  localparam logic [ARCH_REG_WIDTH-1:0] ARCH_X0    = '0;

  state_e                   state;
  logic [PHY_REG_WIDTH-1:0] init_cnt;

  logic [PHY_REG_WIDTH-1:0] spec_rat     [ARCH_REG_NUM];
  logic [PHY_REG_WIDTH-1:0] arch_rat     [ARCH_REG_NUM];
  logic [PHY_REG_WIDTH-1:0] arch_rat_nxt [ARCH_REG_NUM];

  logic run;
  logic need_alloc;
  logic out_free;
  logic dec_ready;
  logic fire;
  logic alloc;
  logic commit_wr;
  logic flush_run;

  // Handshakes: a transfer happens on a posedge where valid and ready are both high.
  // Decode side: dec_ready_o never depends on dec_valid_i. Output side: once ren_valid_o
  // is high its payload holds until ren_ready_i is seen; flush drops it unconditionally.

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= INIT_FIRST;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + PHY_REG_WIDTH'(1);
          if (init_cnt == INIT_LAST) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.dbg_state = state;

  assign run        = (state == ST_RUN) & ~rst;
  assign need_alloc = bus.dec_rd_wen_i & (bus.dec_rd_i != ARCH_X0);
  assign out_free   = ~bus.ren_valid_o | bus.ren_ready_i;
  assign dec_ready  = run & out_free & ~(need_alloc & bus.fl_empty_i) & ~bus.flush_i;
  assign fire       = bus.dec_valid_i & dec_ready;
  assign alloc      = fire & need_alloc;
  assign commit_wr  = run & bus.cmt_valid_i & bus.cmt_rd_wen_i & (bus.cmt_rd_i != ARCH_X0);
  assign flush_run  = run & bus.flush_i;

  assign bus.dec_ready_o = dec_ready;
  assign bus.fl_rd_en_o  = alloc;

  // During INIT the write port seeds the free list; afterwards it forwards ROB returns.
  assign bus.fl_wr_en_o = rst ? 1'b0 : ((state == ST_INIT) ? 1'b1 : bus.rob_free_valid_i);
  assign bus.fl_wdata_o = (state == ST_INIT) ? init_cnt : bus.rob_free_prd_i;

  // Post-commit architectural view, so a flush in a commit cycle sees that commit.
  always_comb begin
    for (int i = 0; i < ARCH_REG_NUM; i++) begin
      arch_rat_nxt[i] = arch_rat[i];
    end
    if (commit_wr) arch_rat_nxt[bus.cmt_rd_i] = bus.cmt_prd_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REG_NUM; i++) begin
        spec_rat[i] <= PHY_REG_WIDTH'(i);
        arch_rat[i] <= PHY_REG_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < ARCH_REG_NUM; i++) begin
        arch_rat[i] <= arch_rat_nxt[i];
      end
      if (flush_run) begin
        for (int i = 0; i < ARCH_REG_NUM; i++) begin
          spec_rat[i] <= arch_rat_nxt[i];
        end
      end else if (alloc) begin
        spec_rat[bus.dec_rd_i] <= bus.fl_rdata_i;
      end
    end
  end

  // Sources read the pre-update mapping, so rs == rd returns the old physical reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ren_valid_o   <= 1'b0;
      bus.ren_prs1_o    <= PRD_ZERO;
      bus.ren_prs2_o    <= PRD_ZERO;
      bus.ren_prd_o     <= PRD_ZERO;
      bus.ren_old_prd_o <= PRD_ZERO;
      bus.ren_rd_wen_o  <= 1'b0;
    end else if (flush_run) begin
      bus.ren_valid_o <= 1'b0;
    end else if (fire) begin
      bus.ren_valid_o   <= 1'b1;
      bus.ren_prs1_o    <= (bus.dec_rs1_i == ARCH_X0) ? PRD_ZERO : spec_rat[bus.dec_rs1_i];
      bus.ren_prs2_o    <= (bus.dec_rs2_i == ARCH_X0) ? PRD_ZERO : spec_rat[bus.dec_rs2_i];
      bus.ren_old_prd_o <= spec_rat[bus.dec_rd_i];
      bus.ren_prd_o     <= need_alloc ? bus.fl_rdata_i : PRD_ZERO;
      bus.ren_rd_wen_o  <= need_alloc;
    end else if (bus.ren_ready_i) begin
      bus.ren_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rename_rat.sv
// Directed bench for rename_rat: a queue models the free-list FIFO, each scenario task
// drives decode/commit/flush vectors and checks hand-computed renamed outputs.
module tb_rename_rat;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [5:0] fl_q[$];

  rename_rat_if bus();

  rename_rat dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Free-list FIFO model: pops from the head, pushes to the tail, cleared by reset.
  always @(posedge clk) begin
    if (rst) begin
      fl_q.delete();
    end else begin
      if (bus.fl_rd_en_o && fl_q.size() > 0) void'(fl_q.pop_front());
      if (bus.fl_wr_en_o) fl_q.push_back(bus.fl_wdata_o);
    end
  end

  always @(negedge clk) begin
    bus.fl_empty_i = (fl_q.size() == 0);
    bus.fl_rdata_i = (fl_q.size() == 0) ? 6'd0 : fl_q[0];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen);
    bus.dec_valid_i  = v;
    bus.dec_rs1_i    = rs1;
    bus.dec_rs2_i    = rs2;
    bus.dec_rd_i     = rd;
    bus.dec_rd_wen_i = wen;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.ren_valid_o !== 1'b0) begin errors++; $display("FAIL reset_ren_valid: got %b expected 0", bus.ren_valid_o); end
    checks++; if (bus.dec_ready_o !== 1'b0) begin errors++; $display("FAIL reset_dec_ready: got %b expected 0", bus.dec_ready_o); end
    checks++; if (bus.fl_wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_fl_wr_en: got %b expected 0", bus.fl_wr_en_o); end
    checks++; if (bus.fl_rd_en_o !== 1'b0) begin errors++; $display("FAIL reset_fl_rd_en: got %b expected 0", bus.fl_rd_en_o); end
    checks++; if (bus.ren_prd_o !== 6'd0) begin errors++; $display("FAIL reset_ren_prd: got %0d expected 0", bus.ren_prd_o); end
    checks++; if (bus.dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", bus.dbg_state); end
  endtask

  task automatic test_init;
    logic [5:0] exp_data;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      exp_data = 6'(32 + i);
      checks++; if (bus.fl_wr_en_o !== 1'b1 || bus.fl_wdata_o !== exp_data) begin errors++; $display("FAIL init_push[%0d]: got en=%b data=%0d expected en=1 data=%0d", i, bus.fl_wr_en_o, bus.fl_wdata_o, exp_data); end
      checks++; if (bus.dec_ready_o !== 1'b0) begin errors++; $display("FAIL init_dec_ready[%0d]: got %b expected 0", i, bus.dec_ready_o); end
      @(negedge clk);
    end
    #1;
    checks++; if (bus.dec_ready_o !== 1'b1) begin errors++; $display("FAIL init_done_dec_ready: got %b expected 1", bus.dec_ready_o); end
    checks++; if (bus.fl_wr_en_o !== 1'b0) begin errors++; $display("FAIL init_done_fl_wr_en: got %b expected 0", bus.fl_wr_en_o); end
    checks++; if (bus.ren_valid_o !== 1'b0) begin errors++; $display("FAIL init_done_ren_valid: got %b expected 0", bus.ren_valid_o); end
    checks++; if (bus.dbg_state !== 1'b1) begin errors++; $display("FAIL init_done_state: got %b expected 1", bus.dbg_state); end
    checks++; if (fl_q.size() != 32) begin errors++; $display("FAIL init_fl_count: got %0d expected 32", fl_q.size()); end
  endtask

  task automatic test_basic;
    bus.ren_ready_i = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
    #1;
    checks++; if (bus.dec_ready_o !== 1'b1 || bus.fl_rd_en_o !== 1'b1) begin errors++; $display("FAIL basic_add_fire: got ready=%b rd_en=%b expected 1 1", bus.dec_ready_o, bus.fl_rd_en_o); end
    @(negedge clk);
    drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1);
    checks++; if (bus.ren_valid_o !== 1'b1) begin errors++; $display("FAIL basic_add_valid: got %b expected 1", bus.ren_valid_o); end
    checks++; if (bus.ren_prs1_o !== 6'd1 || bus.ren_prs2_o !== 6'd2) begin errors++; $display("FAIL basic_add_prs: got %0d %0d expected 1 2", bus.ren_prs1_o, bus.ren_prs2_o); end
    checks++; if (bus.ren_prd_o !== 6'd32 || bus.ren_old_prd_o !== 6'd5) begin errors++; $display("FAIL basic_add_prd: got prd=%0d old=%0d expected 32 5", bus.ren_prd_o, bus.ren_old_prd_o); end
    checks++; if (bus.ren_rd_wen_o !== 1'b1) begin errors++; $display("FAIL basic_add_wen: got %b expected 1", bus.ren_rd_wen_o); end
    #1;
    checks++; if (bus.fl_rd_en_o !== 1'b1) begin errors++; $display("FAIL basic_sub_fire: got %b expected 1", bus.fl_rd_en_o); end
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.ren_prs1_o !== 6'd32 || bus.ren_prs2_o !== 6'd32) begin errors++; $display("FAIL basic_sub_prs: got %0d %0d expected 32 32", bus.ren_prs1_o, bus.ren_prs2_o); end
    checks++; if (bus.ren_prd_o !== 6'd33 || bus.ren_old_prd_o !== 6'd6) begin errors++; $display("FAIL basic_sub_prd: got prd=%0d old=%0d expected 33 6", bus.ren_prd_o, bus.ren_old_prd_o); end
    @(negedge clk);
    checks++; if (bus.ren_valid_o !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b expected 0", bus.ren_valid_o); end
  endtask

  task automatic test_no_alloc;
    drive(1'b1, 5'd5, 5'd6, 5'd0, 1'b1);
    #1;
    checks++; if (bus.dec_ready_o !== 1'b1 || bus.fl_rd_en_o !== 1'b0) begin errors++; $display("FAIL x0_fire: got ready=%b rd_en=%b expected 1 0", bus.dec_ready_o, bus.fl_rd_en_o); end
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd5, 5'd5, 1'b0);
    checks++; if (bus.ren_prs1_o !== 6'd32 || bus.ren_prs2_o !== 6'd33) begin errors++; $display("FAIL x0_prs: got %0d %0d expected 32 33", bus.ren_prs1_o, bus.ren_prs2_o); end
    checks++; if (bus.ren_prd_o !== 6'd0 || bus.ren_rd_wen_o !== 1'b0 || bus.ren_old_prd_o !== 6'd0) begin errors++; $display("FAIL x0_prd: got prd=%0d wen=%b old=%0d expected 0 0 0", bus.ren_prd_o, bus.ren_rd_wen_o, bus.ren_old_prd_o); end
    #1;
    checks++; if (bus.fl_rd_en_o !== 1'b0) begin errors++; $display("FAIL nowen_rd_en: got %b expected 0", bus.fl_rd_en_o); end
    @(negedge clk);
    drive(1'b1, 5'd5, 5'd0, 5'd9, 1'b0);
    checks++; if (bus.ren_prd_o !== 6'd0 || bus.ren_rd_wen_o !== 1'b0) begin errors++; $display("FAIL nowen_prd: got prd=%0d wen=%b expected 0 0", bus.ren_prd_o, bus.ren_rd_wen_o); end
    checks++; if (bus.ren_old_prd_o !== 6'd32 || bus.ren_prs1_o !== 6'd1 || bus.ren_prs2_o !== 6'd32) begin errors++; $display("FAIL nowen_map: got old=%0d prs1=%0d prs2=%0d expected 32 1 32", bus.ren_old_prd_o, bus.ren_prs1_o, bus.ren_prs2_o); end
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.ren_prs1_o !== 6'd32 || bus.ren_prs2_o !== 6'd0 || bus.ren_old_prd_o !== 6'd9) begin errors++; $display("FAIL rat_unchanged: got prs1=%0d prs2=%0d old=%0d expected 32 0 9", bus.ren_prs1_o, bus.ren_prs2_o, bus.ren_old_prd_o); end
    @(negedge clk);
    checks++; if (fl_q.size() != 30) begin errors++; $display("FAIL no_alloc_fl_count: got %0d expected 30", fl_q.size()); end
  endtask

  task automatic test_empty;
    logic [5:0] exp_prd;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1);
      #1;
      checks++; if (bus.fl_rd_en_o !== 1'b1) begin errors++; $display("FAIL drain_pop[%0d]: got %b expected 1", i, bus.fl_rd_en_o); end
      @(negedge clk);
      exp_prd = 6'(34 + i);
      checks++; if (bus.ren_prd_o !== exp_prd) begin errors++; $display("FAIL drain_prd[%0d]: got %0d expected %0d", i, bus.ren_prd_o, exp_prd); end
    end
    drive(1'b1, 5'd10, 5'd0, 5'd11, 1'b1);
    #1;
    checks++; if (bus.dec_ready_o !== 1'b0 || bus.fl_rd_en_o !== 1'b0) begin errors++; $display("FAIL empty_stall: got ready=%b rd_en=%b expected 0 0", bus.dec_ready_o, bus.fl_rd_en_o); end
    @(negedge clk);
    #1;
    checks++; if (bus.dec_ready_o !== 1'b0) begin errors++; $display("FAIL empty_stall2: got %b expected 0", bus.dec_ready_o); end
    checks++; if (bus.ren_valid_o !== 1'b0) begin errors++; $display("FAIL empty_drain: got %b expected 0", bus.ren_valid_o); end
    drive(1'b1, 5'd10, 5'd0, 5'd12, 1'b0);
    #1;
    checks++; if (bus.dec_ready_o !== 1'b1 || bus.fl_rd_en_o !== 1'b0) begin errors++; $display("FAIL empty_nowrite: got ready=%b rd_en=%b expected 1 0", bus.dec_ready_o, bus.fl_rd_en_o); end
    @(negedge clk);
    checks++; if (bus.ren_valid_o !== 1'b1 || bus.ren_prs1_o !== 6'd63 || bus.ren_prd_o !== 6'd0) begin errors++; $display("FAIL empty_nowrite_out: got valid=%b prs1=%0d prd=%0d expected 1 63 0", bus.ren_valid_o, bus.ren_prs1_o, bus.ren_prd_o); end
    drive(1'b1, 5'd10, 5'd0, 5'd11, 1'b1);
    bus.rob_free_valid_i = 1'b1;
    bus.rob_free_prd_i   = 6'd40;
    #1;
    checks++; if (bus.dec_ready_o !== 1'b0) begin errors++; $display("FAIL rob_ret_stall: got %b expected 0", bus.dec_ready_o); end
    checks++; if (bus.fl_wr_en_o !== 1'b1 || bus.fl_wdata_o !== 6'd40) begin errors++; $display("FAIL rob_ret_push: got en=%b data=%0d expected 1 40", bus.fl_wr_en_o, bus.fl_wdata_o); end
    @(negedge clk);
    bus.rob_free_valid_i = 1'b0;
    #1;
    checks++; if (bus.dec_ready_o !== 1'b1 || bus.fl_rd_en_o !== 1'b1) begin errors++; $display("FAIL rob_ret_fire: got ready=%b rd_en=%b expected 1 1", bus.dec_ready_o, bus.fl_rd_en_o); end
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.ren_prd_o !== 6'd40 || bus.ren_prs1_o !== 6'd63 || bus.ren_old_prd_o !== 6'd11) begin errors++; $display("FAIL rob_ret_out: got prd=%0d prs1=%0d old=%0d expected 40 63 11", bus.ren_prd_o, bus.ren_prs1_o, bus.ren_old_prd_o); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bus.rob_free_valid_i = 1'b1;
    for (int p = 41; p <= 43; p++) begin
      bus.rob_free_prd_i = 6'(p);
      @(negedge clk);
    end
    bus.rob_free_valid_i = 1'b0;
    drive(1'b1, 5'd11, 5'd0, 5'd13, 1'b1);
    #1;
    checks++; if (bus.dec_ready_o !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b expected 1", bus.dec_ready_o); end
    @(negedge clk);
    drive(1'b1, 5'd13, 5'd0, 5'd14, 1'b1);
    bus.ren_ready_i = 1'b0;
    checks++; if (bus.ren_prd_o !== 6'd41 || bus.ren_prs1_o !== 6'd40 || bus.ren_old_prd_o !== 6'd13) begin errors++; $display("FAIL bp_first_out: got prd=%0d prs1=%0d old=%0d expected 41 40 13", bus.ren_prd_o, bus.ren_prs1_o, bus.ren_old_prd_o); end
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.dec_ready_o !== 1'b0 || bus.fl_rd_en_o !== 1'b0) begin errors++; $display("FAIL bp_hold_stall[%0d]: got ready=%b rd_en=%b expected 0 0", c, bus.dec_ready_o, bus.fl_rd_en_o); end
      checks++; if (bus.ren_valid_o !== 1'b1 || bus.ren_prd_o !== 6'd41) begin errors++; $display("FAIL bp_hold_out[%0d]: got valid=%b prd=%0d expected 1 41", c, bus.ren_valid_o, bus.ren_prd_o); end
      @(negedge clk);
    end
    bus.ren_ready_i = 1'b1;
    #1;
    checks++; if (bus.dec_ready_o !== 1'b1 || bus.fl_rd_en_o !== 1'b1) begin errors++; $display("FAIL bp_release: got ready=%b rd_en=%b expected 1 1", bus.dec_ready_o, bus.fl_rd_en_o); end
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.ren_prd_o !== 6'd42 || bus.ren_prs1_o !== 6'd41 || bus.ren_old_prd_o !== 6'd14) begin errors++; $display("FAIL bp_second_out: got prd=%0d prs1=%0d old=%0d expected 42 41 14", bus.ren_prd_o, bus.ren_prs1_o, bus.ren_old_prd_o); end
    @(negedge clk);
    checks++; if (bus.ren_valid_o !== 1'b0) begin errors++; $display("FAIL bp_single_fire: got %b expected 0", bus.ren_valid_o); end
    checks++; if (fl_q.size() != 1) begin errors++; $display("FAIL bp_fl_count: got %0d expected 1", fl_q.size()); end
  endtask

  task automatic test_mid_reset;
    bus.ren_ready_i = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 5'd15, 1'b1);
    @(negedge clk);
    checks++; if (bus.ren_valid_o !== 1'b1 || bus.ren_prd_o !== 6'd43) begin errors++; $display("FAIL mid_pre: got valid=%b prd=%0d expected 1 43", bus.ren_valid_o, bus.ren_prd_o); end
    rst = 1'b1;
    #1;
    checks++; if (bus.dec_ready_o !== 1'b0 || bus.fl_wr_en_o !== 1'b0 || bus.fl_rd_en_o !== 1'b0) begin errors++; $display("FAIL mid_rst_comb: got ready=%b wr=%b rd=%b expected 0 0 0", bus.dec_ready_o, bus.fl_wr_en_o, bus.fl_rd_en_o); end
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    bus.ren_ready_i = 1'b1;
    checks++; if (bus.ren_valid_o !== 1'b0 || bus.ren_prd_o !== 6'd0 || bus.dbg_state !== 1'b0) begin errors++; $display("FAIL mid_rst_regs: got valid=%b prd=%0d state=%b expected 0 0 0", bus.ren_valid_o, bus.ren_prd_o, bus.dbg_state); end
    test_init();
  endtask

  task automatic test_flush;
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    #1;
    checks++; if (bus.fl_rd_en_o !== 1'b1) begin errors++; $display("FAIL flush_r1_pop: got %b expected 1", bus.fl_rd_en_o); end
    @(negedge clk);
    checks++; if (bus.ren_prd_o !== 6'd32 || bus.ren_old_prd_o !== 6'd7) begin errors++; $display("FAIL flush_r1_out: got prd=%0d old=%0d expected 32 7", bus.ren_prd_o, bus.ren_old_prd_o); end
    bus.cmt_valid_i  = 1'b1;
    bus.cmt_rd_wen_i = 1'b1;
    bus.cmt_rd_i     = 5'd7;
    bus.cmt_prd_i    = 6'd32;
    drive(1'b1, 5'd7, 5'd0, 5'd7, 1'b1);
    @(negedge clk);
    checks++; if (bus.ren_prs1_o !== 6'd32 || bus.ren_prd_o !== 6'd33 || bus.ren_old_prd_o !== 6'd32) begin errors++; $display("FAIL flush_r2_out: got prs1=%0d prd=%0d old=%0d expected 32 33 32", bus.ren_prs1_o, bus.ren_prd_o, bus.ren_old_prd_o); end
    bus.flush_i   = 1'b1;
    bus.cmt_rd_i  = 5'd8;
    bus.cmt_prd_i = 6'd34;
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    #1;
    checks++; if (bus.dec_ready_o !== 1'b0 || bus.fl_rd_en_o !== 1'b0) begin errors++; $display("FAIL flush_cycle: got ready=%b rd_en=%b expected 0 0", bus.dec_ready_o, bus.fl_rd_en_o); end
    @(negedge clk);
    bus.flush_i     = 1'b0;
    bus.cmt_valid_i = 1'b0;
    checks++; if (bus.ren_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.ren_valid_o); end
    drive(1'b1, 5'd7, 5'd8, 5'd0, 1'b0);
    #1;
    checks++; if (bus.dec_ready_o !== 1'b1) begin errors++; $display("FAIL flush_after_ready: got %b expected 1", bus.dec_ready_o); end
    @(negedge clk);
    checks++; if (bus.ren_prs1_o !== 6'd32 || bus.ren_prs2_o !== 6'd34) begin errors++; $display("FAIL flush_restore: got prs1=%0d prs2=%0d expected 32 34", bus.ren_prs1_o, bus.ren_prs2_o); end
    drive(1'b1, 5'd5, 5'd0, 5'd12, 1'b1);
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.ren_prs1_o !== 6'd5 || bus.ren_prd_o !== 6'd34 || bus.ren_old_prd_o !== 6'd12) begin errors++; $display("FAIL flush_next_alloc: got prs1=%0d prd=%0d old=%0d expected 5 34 12", bus.ren_prs1_o, bus.ren_prd_o, bus.ren_old_prd_o); end
    @(negedge clk);
  endtask

  initial begin
    rst                  = 1'b1;
    bus.ren_ready_i      = 1'b0;
    bus.rob_free_valid_i = 1'b0;
    bus.rob_free_prd_i   = 6'd0;
    bus.cmt_valid_i      = 1'b0;
    bus.cmt_rd_wen_i     = 1'b0;
    bus.cmt_rd_i         = 5'd0;
    bus.cmt_prd_i        = 6'd0;
    bus.flush_i          = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    test_reset();
    test_init();
    test_basic();
    test_no_alloc();
    test_empty();
    test_back_to_back();
    test_mid_reset();
    test_flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rename_rat.md
Name: rename_rat

Overview:
- Single-issue register rename stage in the RCU.
- Sits between decode and ROB/dispatch and consumes physical register numbers from the free-list FIFO.
- Holds a speculative RAT and an architectural RAT, each mapping 32 arch regs to physical regs, and drives the free-list write port.
- After reset it seeds the free list with physical regs 32..63, then renames one instruction per cycle through a registered output stage.

Parameters:
- ARCH_REG_NUM, 32, number of architectural registers (x0..x31).
- ARCH_REG_WIDTH, 5, arch register index width.
- PHY_REG_NUM, 64, number of physical registers.
- PHY_REG_WIDTH, 6, physical register index width; free-list FIFO is instantiated with FIFO_DATA_WIDTH=PHY_REG_WIDTH, FIFO_SIZE=32.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- dec_valid_i  input  1  decode has an instruction.
- dec_ready_o  output  1  rename accepts the instruction this cycle.
- dec_rs1_i / dec_rs2_i / dec_rd_i  input  5 each  source and destination arch regs.
- dec_rd_wen_i  input  1  instruction writes rd.
- fl_empty_i  input  1  free-list FIFO empty.
- fl_rdata_i  input  6  free-list head entry, read combinationally (show-ahead).
- fl_rd_en_o  output  1  pop the free list.
- fl_wr_en_o  output  1  push to the free list.
- fl_wdata_o  output  6  data pushed to the free list.
- rob_free_valid_i  input  1  ROB returns a retired old_prd.
- rob_free_prd_i  input  6  physical reg being returned.
- ren_valid_o  output  1  renamed instruction valid.
- ren_ready_i  input  1  ROB/dispatch accepts the output.
- ren_prs1_o / ren_prs2_o / ren_prd_o / ren_old_prd_o  output  6 each  renamed operands and previous rd mapping.
- ren_rd_wen_o  output  1  a new prd was allocated.
- cmt_valid_i  input  1  commit of one instruction.
- cmt_rd_wen_i  input  1  committing instruction wrote rd.
- cmt_rd_i  input  5  committed arch rd.
- cmt_prd_i  input  6  committed physical rd.
- flush_i  input  1  pipeline flush (mispredict/exception).

Behaviour:
- **Reset:**
  - FSM goes to INIT and init_cnt=32.
  - Spec RAT[i]=i and arch RAT[i]=i.
  - ren_valid_o=0, all ren_*_o=0, dec_ready_o=0, fl_rd_en_o=0, fl_wr_en_o=0.
  - Reset asserted mid-operation discards everything and restarts INIT.
- **INIT:**
  - Each cycle drives fl_wr_en_o=1 and fl_wdata_o=init_cnt, then init_cnt+1.
  - After pushing 63 (32 cycles), moves to RUN.
  - dec_ready_o=0 throughout; rob_free_valid_i and flush_i are ignored, since nothing is in flight.
- **RUN, free-list write port:** fl_wr_en_o=rob_free_valid_i and fl_wdata_o=rob_free_prd_i, pass-through combinational.
- **RUN, allocation:**
  - need_alloc = dec_rd_wen_i & (dec_rd_i!=0).
  - dec_ready_o = (!ren_valid_o | ren_ready_i) & !(need_alloc & fl_empty_i) & !flush_i.
  - fire = dec_valid_i & dec_ready_o.
  - fl_rd_en_o = fire & need_alloc.
- **Output register, loaded on fire (latency 1 cycle):**
  - ren_prs1_o = (rs1==0) ? 0 : specRAT[rs1]; ren_prs2_o likewise.
  - ren_old_prd_o = specRAT[rd].
  - ren_prd_o = need_alloc ? fl_rdata_i : 0.
  - ren_rd_wen_o = need_alloc.
  - Sources read the mapping before this instruction's rd update (rs==rd yields the old mapping).
- **Spec RAT update:**
  - On fire & need_alloc, specRAT[rd] <= fl_rdata_i.
  - Next instruction sees it (no same-cycle bypass needed).
- **Output handshake:**
  - Output holds while ren_valid_o & !ren_ready_i.
  - ren_valid_o clears when consumed without a new fire.
- **Commit:** if cmt_valid_i & cmt_rd_wen_i & cmt_rd_i!=0, then archRAT[cmt_rd_i] <= cmt_prd_i.
- **Flush:**
  - specRAT <= archRAT in one cycle, using the post-commit value when a commit to the same arch reg happens in that cycle.
  - ren_valid_o <= 0 and no fire that cycle.
  - Free-list restoration of squashed prds is owned by the ROB via rob_free_* and not by this block.
- **Invariants:**
  - x0 is never remapped; specRAT[0] = archRAT[0] = 0.
  - Physical reg 0 is never pushed during INIT.

Test Plan:
1. Release rst, hold dec_valid_i=0 -> fl_wr_en_o=1 for exactly 32 cycles with data 32..63; dec_ready_o=1 from cycle 33; ren_valid_o=0.
2. After INIT, rename add x5,x1,x2 then sub x6,x5,x5 with ren_ready_i=1 -> first output: prs1=1, prs2=2, prd=32, old_prd=5; second: prs1=prs2=32, prd=33, old_prd=6.
3. Rename with rd=x0 and with dec_rd_wen_i=0 -> fl_rd_en_o=0, ren_prd_o=0, ren_rd_wen_o=0, RAT unchanged.
4. Pop all 32 free regs without ROB returns, then present a rd-writing instruction -> dec_ready_o=0 until rob_free_valid_i pushes 40; next cycle it fires with prd=40. A non-writing instruction still fires while empty.
5. Hold ren_ready_i=0 for 3 cycles with dec_valid_i=1 -> output stable, no pops, single fire after ren_ready_i rises.
6. Rename x7->32, commit x7/prd=32, rename x7->33, then flush_i together with commit of x8/prd=34 -> after flush: specRAT[7]=32, specRAT[8]=34, ren_valid_o=0, dec_ready_o=0 during the flush cycle.
